pea_token_fifo: RTL and testbench



---
 rtl/pea_token_fifo.sv | 48 ++++
 tb/tb_pea_token_fifo.sv | 130 +++++++++++++
 2 files changed

// File: rtl/pea_token_fifo.sv
// pea_token_fifo: single-clock token FIFO (capacity buffer_size-1) with registered counts and sticky overflow/underflow flags
module pea_token_fifo #(
  parameter int word_size = 16,
  parameter int buffer_size = 1024,
  localparam int aw = (buffer_size > 1) ? $clog2(buffer_size) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [word_size-1:0] data_in,
  input  logic                 rd_en,
  output logic [word_size-1:0] data_out,
  output logic [aw-1:0]        population,
  output logic [aw-1:0]        free_space,
  output logic                 overflow,
  output logic                 underflow
);
  logic [word_size-1:0] mem [buffer_size];
  logic [aw-1:0] wptr, rptr;
  logic full, empty, push, pop;
  always_comb begin
    full = population == aw'(buffer_size - 1);
    empty = population == '0;
    pop = rd_en && !empty;
    push = wr_en && (!full || pop);
    free_space = aw'(buffer_size - 1) - population;
  end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= data_in;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      population <= '0;
      data_out <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + aw'(1);
      if (pop) begin
        rptr <= rptr + aw'(1);
        data_out <= mem[rptr];
      end
      population <= (push && !pop) ? population + aw'(1) : (pop && !push) ? population - aw'(1) : population;
      if (wr_en && !push) overflow <= 1'b1;
      if (rd_en && !pop) underflow <= 1'b1;
    end
endmodule

// File: tb/tb_pea_token_fifo.sv
// tb_pea_token_fifo: directed and random checks of pea_token_fifo against a queue-based model
module tb_pea_token_fifo;
  logic clk = 0, rst = 1, wr_en = 0, rd_en = 0;
  logic [15:0] data_in = 0, data_out;
  logic [1:0] population, free_space;
  logic overflow, underflow;
  int tests = 0, fails = 0;
  logic [15:0] q[$];
  logic [15:0] m_dout = 0;
  logic m_ovf = 0, m_unf = 0;

  pea_token_fifo #(.word_size(16), .buffer_size(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .population(population), .free_space(free_space),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pop"}, 32'(population), 32'(q.size()));
    chk({tag, ".free"}, 32'(free_space), 32'(3 - q.size()));
    chk({tag, ".dout"}, 32'(data_out), 32'(m_dout));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
  endtask

  task automatic step(input string tag, input logic w, input logic [15:0] d, input logic r);
    bit pop_ok, push_ok;
    wr_en = w;
    data_in = d;
    rd_en = r;
    @(posedge clk);
    pop_ok = r && q.size() > 0;
    push_ok = w && (q.size() < 3 || pop_ok);
    if (pop_ok) m_dout = q.pop_front();
    if (push_ok) q.push_back(d);
    if (w && !push_ok) m_ovf = 1;
    if (r && !pop_ok) m_unf = 1;
    #1;
    wr_en = 0;
    rd_en = 0;
    chk_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1;
    #1;
    q.delete();
    m_dout = 0;
    m_ovf = 0;
    m_unf = 0;
    chk_all(tag);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #2;
    q.delete();
    chk_all("reset");
    chk("reset.free_const", 32'(free_space), 32'd3);
    @(negedge clk);
    rst = 0;
    step("ord_push0", 1, 16'h0011, 0);
    step("ord_push1", 1, 16'h0022, 0);
    step("ord_push2", 1, 16'h0033, 0);
    chk("ord_full_free", 32'(free_space), 32'd0);
    step("ord_pop0", 0, 0, 1);
    chk("ord_d0", 32'(data_out), 32'h0011);
    step("ord_pop1", 0, 0, 1);
    chk("ord_d1", 32'(data_out), 32'h0022);
    step("ord_pop2", 0, 0, 1);
    chk("ord_d2", 32'(data_out), 32'h0033);
    step("unf_pop", 0, 0, 1);
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_dout_held", 32'(data_out), 32'h0033);
    do_reset("rst1");
    step("ovf_push0", 1, 16'h0011, 0);
    step("ovf_push1", 1, 16'h0022, 0);
    step("ovf_push2", 1, 16'h0033, 0);
    step("ovf_push3", 1, 16'h0044, 0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_pop_held", 32'(population), 32'd3);
    step("ovf_pop0", 0, 0, 1);
    chk("ovf_d0", 32'(data_out), 32'h0011);
    step("full_refill", 1, 16'h0055, 0);
    step("full_both", 1, 16'h0066, 1);
    chk("full_both_pop", 32'(population), 32'd3);
    chk("full_both_d", 32'(data_out), 32'h0022);
    step("drain0", 0, 0, 1);
    chk("drain_d0", 32'(data_out), 32'h0033);
    step("drain1", 0, 0, 1);
    chk("drain_d1", 32'(data_out), 32'h0055);
    step("drain2", 0, 0, 1);
    chk("drain_d2", 32'(data_out), 32'h0066);
    do_reset("rst2");
    step("empty_both", 1, 16'h0077, 1);
    chk("empty_both_unf", 32'(underflow), 32'd1);
    chk("empty_both_pop", 32'(population), 32'd1);
    step("empty_both_drain", 0, 0, 1);
    chk("empty_both_d", 32'(data_out), 32'h0077);
    do_reset("rst3");
    step("wrap_first", 1, 16'h0100, 0);
    for (int i = 1; i < 10; i++) begin
      step("wrap", 1, 16'h0100 + 16'(i), 1);
      chk("wrap_d", 32'(data_out), 32'h0100 + 32'(i - 1));
      chk("wrap_pop", 32'(population), 32'd1);
    end
    do_reset("wrap_midrst");
    chk("midrst_pop", 32'(population), 32'd0);
    step("midrst_pop_empty", 0, 0, 1);
    chk("midrst_unf", 32'(underflow), 32'd1);
    do_reset("rst4");
    for (int i = 0; i < 400; i++) begin
      if (i % 97 == 96) do_reset("rnd_rst");
      else step("rnd", 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
